// File: rtl/uart_frame_deser.sv
// Oversampled serial frame receiver: start, DATA_BIT_NUM data bits LSB first,
// even-XOR parity, one stop bit. Delivers each word with a one-cycle valid strobe.
module uart_frame_deser #(
  parameter int DATA_BIT_NUM = 8,
  parameter int OVERSAMPLE   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_pulse,
  input  logic                    din,
  output logic [DATA_BIT_NUM-1:0] dout,
  output logic                    dout_valid,
  output logic                    parity_err,
  output logic                    frame_err,
  output logic                    busy
);

  localparam int OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BC_W = $clog2(DATA_BIT_NUM + 1);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  // Pre-increment compare so the start bit is validated on pulse OVERSAMPLE/2-1.
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 2);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BIT_NUM - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [OS_W-1:0]         os_cnt_q, os_cnt_d;
  logic [BC_W-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_BIT_NUM-1:0] shift_q, shift_d;
  logic                    par_q, par_d;
  logic                    sync1_q, line_s_q, line_prev_q;
  logic [DATA_BIT_NUM-1:0] dout_q, dout_d;
  logic                    dout_valid_q, dout_valid_d;
  logic                    parity_err_q, parity_err_d;
  logic                    frame_err_q, frame_err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      line_s_q    <= 1'b1;
      line_prev_q <= 1'b1;
    end else begin
      sync1_q  <= din;
      line_s_q <= sync1_q;
      if (sample_pulse) line_prev_q <= line_s_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      os_cnt_q     <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      os_cnt_q     <= os_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    os_cnt_d     = os_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    if (sample_pulse) begin
      case (state_q)
        ST_IDLE: begin
          if (!line_s_q && line_prev_q) begin
            state_d  = ST_START;
            os_cnt_d = '0;
          end
        end
        ST_START: begin
          if (os_cnt_q == OS_MID) begin
            os_cnt_d = '0;
            if (line_s_q) begin
              state_d = ST_IDLE;
            end else begin
              state_d   = ST_DATA;
              bit_cnt_d = '0;
            end
          end else begin
            os_cnt_d = os_cnt_q + OS_W'(1);
          end
        end
        ST_DATA: begin
          if (os_cnt_q == OS_LAST) begin
            os_cnt_d  = '0;
            shift_d   = {line_s_q, shift_q[DATA_BIT_NUM-1:1]};
            bit_cnt_d = bit_cnt_q + BC_W'(1);
            if (bit_cnt_q == BC_LAST) state_d = ST_PARITY;
          end else begin
            os_cnt_d = os_cnt_q + OS_W'(1);
          end
        end
        ST_PARITY: begin
          if (os_cnt_q == OS_LAST) begin
            os_cnt_d = '0;
            par_d    = line_s_q;
            state_d  = ST_STOP;
          end else begin
            os_cnt_d = os_cnt_q + OS_W'(1);
          end
        end
        ST_STOP: begin
          // Leaving at mid-stop gives half a bit to catch a back-to-back start edge.
          if (os_cnt_q == OS_LAST) begin
            os_cnt_d     = '0;
            dout_d       = shift_q;
            parity_err_d = par_q ^ (^shift_q);
            frame_err_d  = ~line_s_q;
            dout_valid_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            os_cnt_d = os_cnt_q + OS_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_frame_deser.sv
// Scoreboard bench for uart_frame_deser: frames are driven bit by bit, the
// expected word and flags are queued, and each dout_valid pops and compares.
module tb_uart_frame_deser;

  localparam int DBN = 8;
  localparam int OS  = 16;
  localparam int W   = DBN + 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           sample_pulse = 1'b0;
  logic           din = 1'b1;
  logic [DBN-1:0] dout;
  logic           dout_valid, parity_err, frame_err, busy;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int sp_total = 0;
  int det_idx = 0;
  bit det_seen = 0;
  logic busy_prev = 1'b0;
  logic valid_prev = 1'b0;
  int div = 0;

  uart_frame_deser #(.DATA_BIT_NUM(DBN), .OVERSAMPLE(OS)) dut (
    .clk(clk), .rst(rst), .sample_pulse(sample_pulse), .din(din),
    .dout(dout), .dout_valid(dout_valid), .parity_err(parity_err),
    .frame_err(frame_err), .busy(busy)
  );

  // clock / strobe block
  always #5 clk = ~clk;

  always @(negedge clk) begin
    div = (div + 1) % 4;
    sample_pulse = (div == 0);
  end

  always @(posedge clk) if (sample_pulse) sp_total = sp_total + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // driver tasks
  task automatic wait_sp(input int n);
    repeat (n) begin
      @(posedge clk);
      while (sample_pulse !== 1'b1) @(posedge clk);
    end
  endtask

  task automatic drive_bit(input logic b, input int n);
    @(negedge clk);
    din = b;
    wait_sp(n);
  endtask

  task automatic send_frame(input logic [DBN-1:0] data, input logic par_flip, input logic stop);
    exp_q.push_back({~stop, par_flip, data});
    drive_bit(1'b0, OS);
    for (int i = 0; i < DBN; i++) drive_bit(data[i], OS);
    drive_bit((^data) ^ par_flip, OS);
    drive_bit(stop, OS);
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while ((busy || exp_q.size() != 0) && t < 5000) begin
      @(negedge clk);
      t = t + 1;
    end
    check({tag, "_drain"}, exp_q.size(), 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (rst) begin
      busy_prev  = 1'b0;
      valid_prev = 1'b0;
      det_seen   = 0;
    end else begin
      if (busy && !busy_prev) begin
        det_idx  = sp_total;
        det_seen = 1;
      end
      if (dout_valid) begin
        logic [W-1:0] e;
        check("valid_1clk", valid_prev, 0);
        check("busy_at_valid", busy, 0);
        check("latency", det_seen ? (sp_total - det_idx) : -1, OS / 2 - 1 + OS * (DBN + 2));
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("dout", dout, e[DBN-1:0]);
          check("parity_err", parity_err, e[DBN]);
          check("frame_err", frame_err, e[DBN+1]);
        end
      end
      busy_prev  = busy;
      valid_prev = dout_valid;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    din = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_dout", dout, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_perr", parity_err, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    drive_bit(1'b1, 2 * OS);

    send_frame(8'hA5, 1'b0, 1'b1);
    drive_bit(1'b1, 2 * OS);
    wait_drain("single");

    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    drive_bit(1'b1, 2 * OS);
    wait_drain("b2b");

    send_frame(8'h01, 1'b1, 1'b1);
    send_frame(8'h55, 1'b0, 1'b1);
    drive_bit(1'b1, 2 * OS);
    wait_drain("parity");

    // glitch shorter than half a bit must be rejected
    drive_bit(1'b0, 4);
    check("glitch_busy_hi", busy, 1);
    drive_bit(1'b1, 10);
    check("glitch_busy_lo", busy, 0);
    check("glitch_dout", dout, 8'h55);
    drive_bit(1'b1, 2 * OS);
    wait_drain("glitch");

    // break: one all-zero frame with framing error, then silence
    exp_q.push_back({1'b1, 1'b0, 8'h00});
    drive_bit(1'b0, 400);
    drive_bit(1'b1, 2 * OS);
    send_frame(8'h3C, 1'b0, 1'b1);
    drive_bit(1'b1, 2 * OS);
    wait_drain("break");

    // reset while data bit 3 is arriving
    drive_bit(1'b0, OS);
    drive_bit(1'b1, OS);
    drive_bit(1'b1, OS);
    drive_bit(1'b0, OS);
    drive_bit(1'b0, OS / 2);
    @(negedge clk);
    check("mid_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_dout", dout, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_perr", parity_err, 0);
    check("mid_rst_ferr", frame_err, 0);
    check("mid_rst_valid", dout_valid, 0);
    din = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    drive_bit(1'b1, 2 * OS);
    send_frame(8'hC3, 1'b0, 1'b1);
    drive_bit(1'b1, 2 * OS);
    wait_drain("post_rst");

    // random clean frames
    for (int k = 0; k < 3; k++) begin
      send_frame(DBN'($urandom_range(0, 255)), 1'b0, 1'b1);
    end
    drive_bit(1'b1, 2 * OS);
    wait_drain("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
